// File: rtl/ov5640_power_monitor.sv
// OV5640 power-pin monitor: tracks the sensor power state, flags sequencing faults.
// Optional watchdog enabled by defining POWER_MON_TIMEOUT_EN.
module ov5640_power_monitor #(
    parameter int unsigned MIN_PWDN_CYC = 250_000,
    parameter int unsigned MIN_RST_CYC  = 50_000,
    parameter int unsigned MIN_INIT_CYC = 1_000_000,
`ifdef POWER_MON_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC  = 2_000_000,
`endif
    parameter int unsigned CNT_W        = 21
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             cmos_pwdn,
    input  logic             cmos_reset,
    input  logic             done,
    input  logic             clear_fault,
    output logic             sensor_ready,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] meas_cnt
);

    // state    | meaning
    // S_WAIT   | waiting for pwdn high / reset low
    // S_OFF    | powered down, timing pwdn-high phase
    // S_PWR_UP | pwdn released, reset still held low
    // S_BOOT   | reset released, waiting for init time
    // S_READY  | sensor may be configured over SCCB
    // S_FAULT  | sticky fault, waits for clear_fault
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_OFF    = 3'd1,
        S_PWR_UP = 3'd2,
        S_BOOT   = 3'd3,
        S_READY  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [2:0] C_NONE       = 3'd0;
    localparam logic [2:0] C_PWDN_SHORT = 3'd1;
    localparam logic [2:0] C_ORDER      = 3'd2;
    localparam logic [2:0] C_RST_SHORT  = 3'd3;
    localparam logic [2:0] C_GLITCH     = 3'd4;
    localparam logic [2:0] C_EARLY_DONE = 3'd5;
`ifdef POWER_MON_TIMEOUT_EN
    localparam logic [2:0] C_TIMEOUT    = 3'd6;
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYC);
`endif

    localparam logic [CNT_W-1:0] PWDN_LIM = CNT_W'(MIN_PWDN_CYC);
    localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(MIN_RST_CYC);
    localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(MIN_INIT_CYC);

    logic             p_q, r_q, d_q, p_qq, r_qq;
    logic             p_rise, p_fall, r_rise, r_fall;
    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             ready_q, fault_q;

    always_comb begin
        p_rise  = p_q & ~p_qq;
        p_fall  = ~p_q & p_qq;
        r_rise  = r_q & ~r_qq;
        r_fall  = ~r_q & r_qq;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        state_d = state_q;
        code_d  = code_q;

        case (state_q)
            S_WAIT: begin
                if (p_q && !r_q) state_d = S_OFF;
            end
            S_OFF: begin
                // reset rising with pwdn still (or just) high is an ordering error
                if (r_rise) begin
                    state_d = S_FAULT;
                    code_d  = C_ORDER;
                end else if (p_fall) begin
                    if (cnt_inc < PWDN_LIM) begin
                        state_d = S_FAULT;
                        code_d  = C_PWDN_SHORT;
                    end else begin
                        state_d = S_PWR_UP;
                    end
                end
            end
            S_PWR_UP: begin
                if (p_rise) begin
                    state_d = S_OFF;
                end else if (r_rise) begin
                    if (cnt_inc < RST_LIM) begin
                        state_d = S_FAULT;
                        code_d  = C_RST_SHORT;
                    end else begin
                        state_d = S_BOOT;
                    end
                end
`ifdef POWER_MON_TIMEOUT_EN
                else if (cnt_inc == TO_LIM) begin
                    state_d = S_FAULT;
                    code_d  = C_TIMEOUT;
                end
`endif
            end
            S_BOOT: begin
                if (r_fall || p_rise) begin
                    state_d = S_FAULT;
                    code_d  = C_GLITCH;
                end else if (d_q && (cnt_inc < INIT_LIM)) begin
                    state_d = S_FAULT;
                    code_d  = C_EARLY_DONE;
                end else if (cnt_inc == INIT_LIM) begin
                    state_d = S_READY;
                end
`ifdef POWER_MON_TIMEOUT_EN
                else if (!d_q && (cnt_inc == TO_LIM)) begin
                    state_d = S_FAULT;
                    code_d  = C_TIMEOUT;
                end
`endif
            end
            S_READY: begin
                if (p_rise) begin
                    state_d = S_OFF;
                end else if (r_fall && !p_q) begin
                    state_d = S_FAULT;
                    code_d  = C_GLITCH;
                end
`ifdef POWER_MON_TIMEOUT_EN
                else if (!d_q && (cnt_inc == TO_LIM)) begin
                    state_d = S_FAULT;
                    code_d  = C_TIMEOUT;
                end
`endif
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_WAIT;
                    code_d  = C_NONE;
                end
            end
            default: begin
                state_d = S_WAIT;
                code_d  = C_NONE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            meas_d = cnt_inc;
        end else begin
            cnt_d  = (state_q == S_FAULT) ? cnt_q : cnt_inc;
            meas_d = meas_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            p_q     <= 1'b1;
            r_q     <= 1'b0;
            d_q     <= 1'b0;
            p_qq    <= 1'b1;
            r_qq    <= 1'b0;
            state_q <= S_WAIT;
            code_q  <= C_NONE;
            cnt_q   <= '0;
            meas_q  <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            p_q     <= cmos_pwdn;
            r_q     <= cmos_reset;
            d_q     <= done;
            p_qq    <= p_q;
            r_qq    <= r_q;
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            ready_q <= (state_d == S_READY);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign sensor_ready = ready_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
    assign state        = state_q;
    assign meas_cnt     = meas_q;

endmodule

// File: doc/ov5640_power_monitor.md
Name: ov5640_power_monitor

Overview:
- Observes the OV5640 power-control pins (cmos_pwdn, cmos_reset) and the power-up sequencer's done flag from the sensor side, the way the camera sees them.
- Tracks the sensor power state, reports when the sensor is ready for SCCB configuration, and flags sequencing or timing violations with a sticky fault code.
- Sits beside the power-up sequencer; its outputs gate the SCCB init block and feed debug LEDs and a logic analyser.

Parameters:
- MIN_PWDN_CYC, 250_000, minimum cycles pwdn must be high before release (5 ms at 50 MHz).
- MIN_RST_CYC, 50_000, minimum cycles reset must stay low after pwdn falls (1 ms).
- MIN_INIT_CYC, 1_000_000, minimum cycles after reset rises before the sensor counts as ready (20 ms).
- TIMEOUT_CYC, 2_000_000, watchdog limit; used only with the optional feature.
- CNT_W, 21, phase counter width. Must hold every parameter above.

Ports:
- sysclk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- cmos_pwdn  in  1  observed power-down pin (1 = powered down). Same clock domain as sysclk.
- cmos_reset  in  1  observed reset pin (0 = held in reset).
- done  in  1  power-up sequencer done flag.
- clear_fault  in  1  one-cycle pulse; leaves S_FAULT.
- sensor_ready  out  1  high only in S_READY.
- fault  out  1  high only in S_FAULT.
- fault_code  out  3  0 none, 1 PWDN_SHORT, 2 ORDER, 3 RST_SHORT, 4 GLITCH, 5 EARLY_DONE, 6 TIMEOUT.
- state  out  3  current state encoding, for debug.
- meas_cnt  out  CNT_W  length in cycles of the last completed phase.

Behaviour:
- Inputs are registered once into p_q, r_q, d_q. Edges are detected against a second register stage.
- Reset values:
  - first stage p_q=1, r_q=0, d_q=0; second stage the same, so no edge is seen on exit from reset.
  - state=S_WAIT (0), cnt=0, meas_cnt=0, fault_code=0, sensor_ready=0, fault=0.
- Outputs are registered. A pin event is reflected on the outputs 2 cycles after it appears at the input.
- cnt is a phase counter:
  - increments every cycle and saturates at all-ones;
  - clears to 0 on every state transition;
  - on each transition the current cnt+1 is loaded into meas_cnt.
- S_WAIT (0): wait for p_q=1 and r_q=0, then go to S_OFF.
- S_OFF (1), pwdn high:
  - r_q rises while p_q=1, including the same cycle pwdn falls: S_FAULT, code 2 (ORDER).
  - p_q falls with cnt+1 < MIN_PWDN_CYC: S_FAULT, code 1 (PWDN_SHORT).
  - p_q falls otherwise: S_PWR_UP.
- S_PWR_UP (2), pwdn low, reset low:
  - p_q rises: back to S_OFF (legal re-power-down).
  - r_q rises with cnt+1 < MIN_RST_CYC: S_FAULT, code 3 (RST_SHORT).
  - r_q rises otherwise: S_BOOT.
- S_BOOT (3):
  - r_q falls or p_q rises: S_FAULT, code 4 (GLITCH). This takes priority over everything else in this state.
  - d_q=1 while cnt+1 < MIN_INIT_CYC: S_FAULT, code 5 (EARLY_DONE).
  - cnt+1 == MIN_INIT_CYC: S_READY. If done arrives in that same cycle it is legal.
- S_READY (4):
  - p_q rises: S_OFF, legal shutdown; sensor_ready drops.
  - r_q falls while p_q=0: S_FAULT, code 4 (GLITCH).
- S_FAULT (5):
  - fault=1; fault_code is held; counting stops.
  - clear_fault=1: S_WAIT, fault_code=0.
  - Further pin activity is ignored.
- rst asserted in any state returns every register to its reset value on the next clock edge.

Optional Feature:
- Macro: POWER_MON_TIMEOUT_EN.
- Defined:
  - In S_PWR_UP, or in S_BOOT/S_READY while d_q=0, cnt+1 == TIMEOUT_CYC enters S_FAULT with code 6 (TIMEOUT).
  - In S_READY the watchdog stops once done is high.
- Undefined: no watchdog; code 6 is never produced; TIMEOUT_CYC is unused.

Test Plan:
- Nominal sequence: pwdn high 300_000 cycles, reset low a further 100_000, then reset high; done rises 1_049_998 cycles after reset rises.
  - Expected: S_OFF, S_PWR_UP, S_BOOT, S_READY.
  - sensor_ready rises 1_000_001 cycles after the reset rising edge at the input; fault stays 0.
- pwdn released after 200_000 cycles: fault=1, fault_code=1, meas_cnt=200_000.
- reset released 10_000 cycles after pwdn falls: fault_code=3. Then pulse clear_fault: state returns to 0 and fault drops.
- done pulsed 500_000 cycles after reset rises: fault_code=5.
- 1-cycle low glitch on cmos_reset in S_READY gives fault_code=4. A separate run with pwdn rising in S_READY gives a return to S_OFF with no fault.
- rst asserted mid-S_BOOT: all outputs at reset values on the next clock edge. With POWER_MON_TIMEOUT_EN, pwdn released but reset held low for 2_000_000 cycles gives fault_code=6.
